rom_loader: RTL

Parametrised SD-to-SRAM cartridge image loader and console ROM port. Owns the external SRAM during a load and copies 2^SECTORS_LOG2 512-byte sectors of the selected image from the SD sector reader (`sd_access`). It holds the console in reset throughout the load, then serves console ROM reads from SRAM. Compared with the previous selector, it adds:
- configurable image size and widths;
- a byte-wait timeout;
- an explicit error state;
- a clean load/reset handshake.

---
 rtl/rom_loader_pkg.sv | 47 ++++
 rtl/rom_loader_sram_mux.sv | 65 ++++++
 rtl/rom_loader.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_loader_pkg
//  Description : Shared types and constants for the SD-to-SRAM ROM loader.
//                Holds the loader state encoding, the sector size, the byte
//                index width and helpers that classify states and derive the
//                image address width from the sector count.
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_loader_pkg;

    // Loader states, explicitly encoded in 4 bits.
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ARM       = 4'd1,
        S_CHECK     = 4'd2,
        S_SECTOR    = 4'd3,
        S_WAIT_BYTE = 4'd4,
        S_WAIT_REL  = 4'd5,
        S_WR_SETUP  = 4'd6,
        S_WR_PULSE  = 4'd7,
        S_WR_HOLD   = 4'd8,
        S_DONE      = 4'd9,
        S_ERROR     = 4'd10
    } state_t;

    localparam int SECTOR_BYTES = 512;
    localparam int c_byte_aw    = 9;     // log2(SECTOR_BYTES)

    // Width of a byte offset inside one image.
    function automatic int image_aw(input int sectors_log2);
        return sectors_log2 + c_byte_aw;
    endfunction

    // States in which the loader owns the SRAM and reports busy.
    function automatic logic state_is_busy(input state_t s);
        return s inside {S_CHECK, S_SECTOR, S_WAIT_BYTE, S_WAIT_REL,
                         S_WR_SETUP, S_WR_PULSE, S_WR_HOLD};
    endfunction

    // States during which the SRAM data bus is driven by the loader.
    function automatic logic state_drives_bus(input state_t s);
        return s inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_loader_sram_mux.sv
`default_nettype none
// ============================================================================
//  Module      : rom_loader_sram_mux
//  Description : SRAM side of the ROM loader. Selects the SRAM address
//                between the loader and the console, gates console read data
//                and registers the SRAM write-enable and bus-enable strobes.
//
//  Ports:
//    clk, rst_n      clock / asynchronous active-low reset
//    busy            loader owns the SRAM
//    load_addr       loader write address
//    we_n_next       write strobe value for the next cycle (active low)
//    oe_next         bus-drive enable for the next cycle
//    cpu_addr        console address
//    cpu_en_n        console read enable (active low)
//    sram_din        data read back from the SRAM
//    sram_addr       SRAM address
//    sram_we_n       SRAM write enable (active low)
//    sram_oe         tristate enable for the SRAM data bus
//    cpu_data        console read data (8'hFF when not enabled or loading)
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_loader_sram_mux #(
    parameter int SRAM_AW = 19,
    parameter int CPU_AW  = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               busy,
    input  logic [SRAM_AW-1:0] load_addr,
    input  logic               we_n_next,
    input  logic               oe_next,
    input  logic [CPU_AW-1:0]  cpu_addr,
    input  logic               cpu_en_n,
    input  logic [7:0]         sram_din,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic               sram_oe,
    output logic [7:0]         cpu_data
);

    logic r_we_n;
    logic r_oe;

    // Registered strobes; the asynchronous reset drops a write in progress
    // immediately rather than waiting for the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we_n <= 1'b1;
            r_oe   <= 1'b0;
        end else begin
            r_we_n <= we_n_next;
            r_oe   <= oe_next;
        end
    end

    assign sram_we_n = r_we_n;
    assign sram_oe   = r_oe;

    // Console read path is purely combinational from the SRAM data pins.
    assign sram_addr = busy ? load_addr : SRAM_AW'(cpu_addr);
    assign cpu_data  = (!busy && !cpu_en_n) ? sram_din : 8'hFF;

endmodule
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : rom_loader
//  Description : SD-to-SRAM cartridge image loader and console ROM port.
//                On release of load_req it copies 2^SECTORS_LOG2 sectors of
//                the selected image from the SD sector reader into SRAM while
//                holding the console in reset, then serves console ROM reads
//                from SRAM. A byte-wait timeout and SD loss lead to a sticky
//                error state.
//                Optional feature macro: ROM_LOADER_CHECKSUM_EN adds a 16-bit
//                wrapping sum of all written bytes on the checksum port
//                (tied to zero when the macro is not defined).
//
//  Ports:
//    clk, rst_n        clock / asynchronous active-low reset
//    load_req          load request level; load starts on its release
//    rom_sel           image index, sampled on release of load_req
//    cur_rom           latched image index
//    busy              high while loading
//    done              one-cycle pulse on successful completion
//    error             sticky error flag, cleared at the next load start
//    sd_initialized    SD reader ready
//    sd_busy           SD reader busy
//    sd_start          one-cycle sector read request
//    sd_sector         sector address
//    sd_data, sd_rd_n  byte from the reader, valid while sd_rd_n is low
//    sram_*            external SRAM interface
//    cpu_addr/en_n     console ROM read port
//    cpu_data          console read data
//    cpu_rst_n         console reset (active low)
//    checksum          16-bit sum of loaded bytes (feature macro)
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int SECTORS_LOG2 = 4,
    parameter int ROM_ID_W     = 16,
    parameter int SRAM_AW      = 19,
    parameter int CPU_AW       = 13,
    parameter int TIMEOUT_W    = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_req,
    input  logic [ROM_ID_W-1:0] rom_sel,
    output logic [ROM_ID_W-1:0] cur_rom,
    output logic                busy,
    output logic                done,
    output logic                error,
    input  logic                sd_initialized,
    input  logic                sd_busy,
    output logic                sd_start,
    output logic [31:0]         sd_sector,
    input  logic [7:0]          sd_data,
    input  logic                sd_rd_n,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [7:0]          sram_dout,
    output logic                sram_oe,
    input  logic [7:0]          sram_din,
    output logic                sram_we_n,
    input  logic [CPU_AW-1:0]   cpu_addr,
    input  logic                cpu_en_n,
    output logic [7:0]          cpu_data,
    output logic                cpu_rst_n,
    output logic [15:0]         checksum
);

    localparam int IMAGE_AW = image_aw(SECTORS_LOG2);
    localparam int c_sec_w  = SECTORS_LOG2 + 1;   // holds 0 .. 2^SECTORS_LOG2
    localparam int c_byte_w = c_byte_aw + 1;       // holds 0 .. SECTOR_BYTES

    state_t                r_state;
    state_t                w_next;
    logic [c_sec_w-1:0]    r_sector;
    logic [c_byte_w-1:0]   r_byte;
    logic [TIMEOUT_W-1:0]  r_tmo;
    logic [ROM_ID_W-1:0]   r_cur_rom;
    logic [7:0]            r_sram_dout;
    logic                  r_error;
    logic                  r_done;
    logic                  r_sd_start;
    logic                  r_cpu_rst_n;

    logic                  w_clr_cnt;
    logic                  w_sector_inc;
    logic                  w_byte_inc;
    logic                  w_latch_byte;
    logic                  w_latch_rom;
    logic                  w_start;
    logic                  w_image_end;
    logic                  w_sector_end;
    logic                  w_tmo_sat;
    logic                  w_busy;
    logic                  w_hold_next;
    logic [IMAGE_AW-1:0]   w_image_addr;

    // The sector counter runs from zero, so its top bit marks 2^SECTORS_LOG2.
    assign w_image_end  = r_sector[SECTORS_LOG2];
    assign w_sector_end = (r_byte == c_byte_w'(SECTOR_BYTES));
    assign w_tmo_sat    = &r_tmo;
    assign w_busy       = state_is_busy(r_state);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next       = r_state;
        w_clr_cnt    = 1'b0;
        w_sector_inc = 1'b0;
        w_byte_inc   = 1'b0;
        w_latch_byte = 1'b0;
        w_latch_rom  = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (load_req) w_next = S_ARM;
            end
            S_ARM: begin
                if (!load_req) begin
                    w_latch_rom = 1'b1;
                    w_next      = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!sd_initialized) begin
                    w_next = S_ERROR;
                end else if (!sd_busy) begin
                    w_clr_cnt = 1'b1;
                    w_next    = S_SECTOR;
                end
            end
            S_SECTOR: begin
                if (w_image_end) begin
                    w_next = S_DONE;
                end else if (!sd_busy) begin
                    w_start = 1'b1;
                    w_next  = S_WAIT_BYTE;
                end
            end
            S_WAIT_BYTE: begin
                if (w_sector_end) begin
                    w_sector_inc = 1'b1;
                    w_next       = S_SECTOR;
                end else if (!sd_rd_n) begin
                    w_latch_byte = 1'b1;
                    w_next       = S_WAIT_REL;
                end else if (!sd_initialized || w_tmo_sat) begin
                    w_next = S_ERROR;
                end
            end
            S_WAIT_REL: begin
                if (sd_rd_n) begin
                    w_next = S_WR_SETUP;
                end else if (w_tmo_sat) begin
                    w_next = S_ERROR;
                end
            end
            S_WR_SETUP: w_next = S_WR_PULSE;
            S_WR_PULSE: w_next = S_WR_HOLD;
            S_WR_HOLD: begin
                w_byte_inc = 1'b1;
                w_next     = S_WAIT_BYTE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Console stays in reset from ARM through the first DONE cycle and
    // in ERROR; it is released on the second cycle of DONE.
    assign w_hold_next = (w_next == S_ARM) || (w_next == S_ERROR) ||
                         state_is_busy(w_next) ||
                         ((w_next == S_DONE) && (r_state != S_DONE));

    // ------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sector    <= '0;
            r_byte      <= '0;
            r_tmo       <= '0;
            r_cur_rom   <= '0;
            r_sram_dout <= 8'h00;
            r_error     <= 1'b0;
            r_done      <= 1'b0;
            r_sd_start  <= 1'b0;
            r_cpu_rst_n <= 1'b1;
        end else begin
            r_state     <= w_next;
            r_sd_start  <= w_start;
            r_done      <= (w_next == S_DONE) && (r_state != S_DONE);
            r_cpu_rst_n <= !w_hold_next;

            if ((w_next == S_ARM) && (r_state != S_ARM)) begin
                r_error <= 1'b0;
            end else if ((w_next == S_ERROR) && (r_state != S_ERROR)) begin
                r_error <= 1'b1;
            end

            if (w_latch_rom)  r_cur_rom   <= rom_sel;
            if (w_latch_byte) r_sram_dout <= sd_data;

            if (w_clr_cnt) begin
                r_sector <= '0;
                r_byte   <= '0;
            end else if (w_sector_inc) begin
                r_sector <= r_sector + c_sec_w'(1);
                r_byte   <= '0;
            end else if (w_byte_inc) begin
                r_byte   <= r_byte + c_byte_w'(1);
            end

            // Timeout restarts on every state change and saturates.
            if (w_next != r_state) begin
                r_tmo <= '0;
            end else if (((r_state == S_WAIT_BYTE) || (r_state == S_WAIT_REL))
                         && !w_tmo_sat) begin
                r_tmo <= r_tmo + TIMEOUT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Addressing
    // ------------------------------------------------------------------
    assign w_image_addr = {r_sector[SECTORS_LOG2-1:0], r_byte[c_byte_aw-1:0]};
    assign sd_sector    = 32'({r_cur_rom, r_sector[SECTORS_LOG2-1:0]});

    rom_loader_sram_mux #(
        .SRAM_AW (SRAM_AW),
        .CPU_AW  (CPU_AW)
    ) u_sram_mux (
        .clk       (clk),
        .rst_n     (rst_n),
        .busy      (w_busy),
        .load_addr (SRAM_AW'(w_image_addr)),
        .we_n_next (w_next != S_WR_PULSE),
        .oe_next   (state_drives_bus(w_next)),
        .cpu_addr  (cpu_addr),
        .cpu_en_n  (cpu_en_n),
        .sram_din  (sram_din),
        .sram_addr (sram_addr),
        .sram_we_n (sram_we_n),
        .sram_oe   (sram_oe),
        .cpu_data  (cpu_data)
    );

    // ------------------------------------------------------------------
    // Optional image checksum
    // ------------------------------------------------------------------
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] r_checksum;

    // One accumulation per written byte, taken in WR_HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= 16'h0000;
        end else if (r_state == S_ARM) begin
            r_checksum <= 16'h0000;
        end else if (r_state == S_WR_HOLD) begin
            r_checksum <= r_checksum + {8'h00, r_sram_dout};
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 16'h0000;
`endif

    assign cur_rom   = r_cur_rom;
    assign busy      = w_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign sd_start  = r_sd_start;
    assign sram_dout = r_sram_dout;
    assign cpu_rst_n = r_cpu_rst_n;

endmodule
`default_nettype wire
